// File: rtl/paillier_pkg.sv
// Shared types for the Paillier host-side initiator: command codes, controller states
// and the per-command operand-slot valid mask.
package paillier_pkg;

  typedef enum logic [2:0] {
    CMD_ENC  = 3'd0,
    CMD_DEC  = 3'd1,
    CMD_ADD  = 3'd2,
    CMD_SMUL = 3'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_STREAM,
    ST_COLLECT,
    ST_DONE
  } state_e;

  // ENC uses g/m/r/n, DEC uses c/lambda/n, ADD and SMUL use two operands.
  function automatic logic [3:0] op_mask(input cmd_e cmd);
    case (cmd)
      CMD_ENC: return 4'b1111;
      CMD_DEC: return 4'b0111;
      default: return 4'b0011;
    endcase
  endfunction

endpackage

// File: rtl/paillier_word_ram.sv
// N x K word buffer with one write port and a registered, enable-gated read port.
// The read register resets to zero; the storage array does not.
module paillier_word_ram #(
  parameter int K = 128,
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [K-1:0]         wdata,
  input  logic                 re,
  input  logic [$clog2(N)-1:0] raddr,
  output logic [K-1:0]         rdata
);

  logic [K-1:0] mem [N];
  logic [K-1:0] rdata_q, rdata_d;

  // NOTE: the storage array is deliberately left out of reset so it maps onto RAM macros;
  // only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/paillier_host_ctrl.sv
// Host-side initiator: issues a task request, streams up to four preloaded operands to the
// accelerator and collects its N-word result into a readable buffer.
module paillier_host_ctrl
  import paillier_pkg::*;
#(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [1:0]           wr_sel,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [K-1:0]         wr_data,
  input  logic                 start,
  input  logic [2:0]           start_cmd,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           err,
  output logic [$clog2(N):0]   res_cnt,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [K-1:0]         rd_data,
  output logic [2:0]           task_cmd,
  output logic                 task_req,
  output logic [K-1:0]         acc_d0,
  output logic [K-1:0]         acc_d1,
  output logic [K-1:0]         acc_d2,
  output logic [K-1:0]         acc_d3,
  output logic [3:0]           acc_v,
  input  logic [K-1:0]         res_data,
  input  logic                 res_valid
);

  localparam int AW = $clog2(N);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(N);

  state_e          state_q, state_d;
  cmd_e            cmd_q, cmd_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW:0]     res_cnt_q, res_cnt_d;
  logic [2:0]      err_q, err_d;
  logic            busy_q, busy_d, done_q, done_d, task_req_q, task_req_d;
  logic [3:0]      acc_v_q, acc_v_d;
  logic            armed, res_we, slot_re;
  logic [AW-1:0]   slot_raddr;
  logic [K-1:0]    slot_rd [4];

  // Slot reads run one cycle ahead so the registered word lines up with its acc_v cycle.
  assign slot_re    = (state_d == ST_STREAM);
  assign slot_raddr = (state_q == ST_STREAM) ? idx_q + 1'b1 : '0;
  assign armed      = state_q inside {ST_GAP, ST_STREAM, ST_COLLECT};

  for (genvar s = 0; s < 4; s++) begin : g_slot
    paillier_word_ram #(.K(K), .N(N)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en && (state_q == ST_IDLE) && (wr_sel == 2'(s))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (slot_re),
      .raddr (slot_raddr),
      .rdata (slot_rd[s])
    );
  end

  paillier_word_ram #(.K(K), .N(N)) u_res (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (res_we),
    .waddr (res_cnt_q[AW-1:0]),
    .wdata (res_data),
    .re    (1'b1),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    res_cnt_d = res_cnt_q;
    err_d     = err_q;
    res_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d     = '0;
          res_cnt_d = '0;
          if (start_cmd <= 3'd3) begin
            cmd_d   = cmd_e'(start_cmd);
            state_d = ST_REQ;
          end else begin
            err_d[2] = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          idx_d   = '0;
          state_d = ST_STREAM;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_STREAM: begin
        if (idx_q == AW'(N - 1)) begin
          tmo_d   = '0;
          state_d = ST_COLLECT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_COLLECT: begin
        if (res_cnt_q == FULL) begin
          state_d = ST_DONE;
        end else if (res_valid) begin
          tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d[0] = 1'b1;
          state_d  = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Result collector; words beyond N are dropped and flagged.
    if (armed && res_valid) begin
      if (res_cnt_q == FULL) begin
        err_d[1] = 1'b1;
      end else begin
        res_we    = 1'b1;
        res_cnt_d = res_cnt_q + 1'b1;
      end
    end

    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    task_req_d = (state_d == ST_REQ);
    acc_v_d    = (state_d == ST_STREAM) ? op_mask(cmd_d) : 4'b0000;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_ENC;
      gap_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      res_cnt_q  <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      task_req_q <= 1'b0;
      acc_v_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      res_cnt_q  <= res_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      task_req_q <= task_req_d;
      acc_v_q    <= acc_v_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign res_cnt  = res_cnt_q;
  assign task_cmd = cmd_q;
  assign task_req = task_req_q;
  assign acc_v    = acc_v_q;
  assign acc_d0   = slot_rd[0];
  assign acc_d1   = slot_rd[1];
  assign acc_d2   = slot_rd[2];
  assign acc_d3   = slot_rd[3];

endmodule

// File: tb/tb_paillier_host_ctrl.sv
// Directed bench for paillier_host_ctrl (K=128, N=4, GAP=2, TIMEOUT=50) with a scripted
// accelerator that answers on res_data/res_valid.
module tb_paillier_host_ctrl;

  localparam int K       = 128;
  localparam int N       = 4;
  localparam int AW      = 2;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_data;
  logic          start;
  logic [2:0]    start_cmd;
  logic          busy, done, task_req;
  logic [2:0]    err, task_cmd;
  logic [AW:0]   res_cnt;
  logic [AW-1:0] rd_addr;
  logic [K-1:0]  rd_data;
  logic [K-1:0]  acc_d [4];
  logic [3:0]    acc_v;
  logic [K-1:0]  res_data;
  logic          res_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  paillier_host_ctrl #(.K(K), .N(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .start_cmd (start_cmd),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .res_cnt   (res_cnt),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .task_cmd  (task_cmd),
    .task_req  (task_req),
    .acc_d0    (acc_d[0]),
    .acc_d1    (acc_d[1]),
    .acc_d2    (acc_d[2]),
    .acc_d3    (acc_d[3]),
    .acc_v     (acc_v),
    .res_data  (res_data),
    .res_valid (res_valid)
  );

  // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
  task automatic start_task(input logic [2:0] c);
    start = 1'b1;
    start_cmd = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accelerator model: n consecutive result words base+0 .. base+n-1.
  task automatic send_results(input int n, input int base);
    for (int j = 0; j < n; j++) begin
      res_valid = 1'b1;
      res_data  = K'(base + j);
      @(negedge clk);
    end
    res_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_cmd = '0; rd_addr = '0; res_data = '0; res_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, task_req} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, task_req}); end
    n_cmp++; if (acc_v !== 4'b0) begin n_err++; $display("FAIL reset_acc_v: got %b want 0000", acc_v); end
    n_cmp++; if ({err, res_cnt, task_cmd} !== '0) begin n_err++; $display("FAIL reset_err_cnt_cmd: got %b/%0d/%0d want 0", err, res_cnt, task_cmd); end
    for (int s = 0; s < 4; s++) begin
      n_cmp++; if (acc_d[s] !== '0) begin n_err++; $display("FAIL reset_acc_d%0d: got %0h want 0", s, acc_d[s]); end
    end
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enc(input bit reload);
    int cyc;
    if (reload) begin
      for (int s = 0; s < 4; s++)
        for (int i = 0; i < N; i++) begin
          wr_en = 1'b1; wr_sel = 2'(s); wr_addr = AW'(i); wr_data = K'((s + 1) * 16 + i);
          @(negedge clk);
        end
      wr_en = 1'b0;
    end
    start_task(3'd0);
    // c=0 is the REQ cycle, c=1..2 the gap, c=3..6 the four stream words.
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        n_cmp++; if ({busy, task_cmd} !== 4'b1_000) begin n_err++; $display("FAIL enc_req_busy_cmd: got %b want 1000", {busy, task_cmd}); end
      end
      n_cmp++; if (task_req !== 1'(c == 0)) begin n_err++; $display("FAIL enc_task_req c%0d: got %b want %b", c, task_req, (c == 0)); end
      n_cmp++; if (acc_v !== ((c >= 3) ? 4'b1111 : 4'b0000)) begin n_err++; $display("FAIL enc_acc_v c%0d: got %b", c, acc_v); end
      if (c >= 3)
        for (int s = 0; s < 4; s++) begin
          n_cmp++; if (acc_d[s] !== K'((s + 1) * 16 + c - 3)) begin n_err++; $display("FAIL enc_acc_d%0d w%0d: got %0h want %0h", s, c - 3, acc_d[s], (s + 1) * 16 + c - 3); end
        end
    end
    @(negedge clk);
    n_cmp++; if ({acc_v, done} !== 5'b0) begin n_err++; $display("FAIL enc_after_stream: got %b want 00000", {acc_v, done}); end
    send_results(4, 'hE0);
    wait_done(cyc);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL enc_done: got %b want 1 (waited %0d)", done, cyc); end
    n_cmp++; if ({err, res_cnt} !== {3'b000, 3'd4}) begin n_err++; $display("FAIL enc_err_cnt: got %b/%0d want 000/4", err, res_cnt); end
    rd_addr = '0;
    @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL enc_done_pulse: got %b want 00", {done, busy}); end
    for (int j = 0; j < N; j++) begin
      rd_addr = AW'(j);
      @(negedge clk);
      n_cmp++; if (rd_data !== K'('hE0 + j)) begin n_err++; $display("FAIL enc_rd%0d: got %0h want %0h", j, rd_data, 'hE0 + j); end
    end
  endtask

  task automatic test_add();
    start_task(3'd2);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (task_cmd !== 3'd2) begin n_err++; $display("FAIL add_task_cmd: got %0d want 2", task_cmd); end
      end
      n_cmp++; if (acc_v !== ((c >= 3) ? 4'b0011 : 4'b0000)) begin n_err++; $display("FAIL add_acc_v c%0d: got %b", c, acc_v); end
      if (c >= 3) begin
        res_valid = 1'b1;
        res_data  = K'('hA0 + c - 3);
      end
    end
    @(negedge clk);
    res_valid = 1'b0;
    n_cmp++; if ({acc_v, done, res_cnt} !== {4'b0000, 1'b0, 3'd4}) begin n_err++; $display("FAIL add_collect_entry: acc_v %b done %b res_cnt %0d want 0000/0/4", acc_v, done, res_cnt); end
    @(negedge clk);
    n_cmp++; if ({done, err} !== 4'b1_000) begin n_err++; $display("FAIL add_done: got %b want 1000", {done, err}); end
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      rd_addr = AW'(j);
      @(negedge clk);
      n_cmp++; if (rd_data !== K'('hA0 + j)) begin n_err++; $display("FAIL add_rd%0d: got %0h want %0h", j, rd_data, 'hA0 + j); end
    end
  endtask

  task automatic test_dec_timeout();
    int cyc;
    start_task(3'd1);
    // Start and write while busy must both be ignored.
    start = 1'b1; start_cmd = 3'd2;
    wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = K'('hBAD);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_cmp++; if (acc_v !== 4'b0111) begin n_err++; $display("FAIL dec_acc_v: got %b want 0111", acc_v); end
      end
    end
    n_cmp++; if (task_cmd !== 3'd1) begin n_err++; $display("FAIL dec_task_cmd: got %0d want 1", task_cmd); end
    send_results(2, 'hD0);
    wait_done(cyc);
    n_cmp++; if (cyc !== 50) begin n_err++; $display("FAIL dec_timeout_cycles: got %0d want 50", cyc); end
    n_cmp++; if ({done, err, res_cnt} !== {1'b1, 3'b001, 3'd2}) begin n_err++; $display("FAIL dec_done_err_cnt: got %b/%b/%0d want 1/001/2", done, err, res_cnt); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int cyc;
    start_task(3'd3);
    repeat (7) @(negedge clk);
    send_results(5, 'h50);
    wait_done(cyc);
    n_cmp++; if ({done, err, res_cnt} !== {1'b1, 3'b010, 3'd4}) begin n_err++; $display("FAIL ovf_done_err_cnt: got %b/%b/%0d want 1/010/4", done, err, res_cnt); end
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      rd_addr = AW'(j);
      @(negedge clk);
      n_cmp++; if (rd_data !== K'('h50 + j)) begin n_err++; $display("FAIL ovf_rd%0d: got %0h want %0h", j, rd_data, 'h50 + j); end
    end
  endtask

  task automatic test_illegal();
    start_task(3'd5);
    n_cmp++; if ({done, busy, task_req, err} !== 6'b110_100) begin n_err++; $display("FAIL ill_done: got %b want 110100", {done, busy, task_req, err}); end
    start = 1'b1; start_cmd = 3'd0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if ({done, busy, task_req} !== 3'b000) begin n_err++; $display("FAIL ill_idle: got %b want 000", {done, busy, task_req}); end
    @(negedge clk);
    n_cmp++; if ({busy, task_req, res_cnt, task_cmd} !== {2'b00, 3'd0, 3'd3}) begin n_err++; $display("FAIL ill_ignored_start: got %b/%b/%0d/%0d want 0/0/0/3", busy, task_req, res_cnt, task_cmd); end
  endtask

  task automatic test_reset_mid_stream();
    start_task(3'd0);
    repeat (3) @(negedge clk);
    n_cmp++; if (acc_v !== 4'b1111) begin n_err++; $display("FAIL rst_pre_stream: got %b want 1111", acc_v); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({acc_v, task_req, busy} !== 6'b0) begin n_err++; $display("FAIL rst_abort: got %b want 000000", {acc_v, task_req, busy}); end
    n_cmp++; if ({err, res_cnt} !== '0) begin n_err++; $display("FAIL rst_err_cnt: got %b/%0d want 0/0", err, res_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_enc(1'b0);
  endtask

  initial begin
    test_reset();
    test_enc(1'b1);
    test_add();
    test_dec_timeout();
    test_overflow();
    test_illegal();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
